// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter that shares one SPI flash between two read requesters,
// issuing READ (0x03) + 24-bit address and streaming bytes back to the owner.
module flash_read_arbiter #(
  parameter int CLK_FREQ        = 27000000,
  parameter int STARTUP_WAIT_MS = 10,
  parameter int MIN_DESELECT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [5:0]  len0,
  input  logic [5:0]  len1,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic [7:0]  rdData,
  output logic        rdValid,
  output logic        rdOwner,
  output logic [1:0]  done,
  output logic        flashClk,
  output logic        flashMosi,
  input  logic        flashMiso,
  output logic        flashCs
);

  localparam int STARTUP_CYCLES = STARTUP_WAIT_MS * CLK_FREQ / 1000;
  localparam int CNT_MAX = (STARTUP_CYCLES > MIN_DESELECT) ? STARTUP_CYCLES : MIN_DESELECT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DESEL_LAST = CNT_W'(MIN_DESELECT - 1);

  typedef enum logic [2:0] {
    WAIT_POWER, IDLE, LOAD_CMD, SEND, LOAD_ADDR, READ, FINISH, DESELECT
  } stateT;

  stateT            state;
  logic [CNT_W-1:0] cnt;
  logic [23:0]      shiftReg;
  logic [23:0]      addrLat;
  logic [5:0]       lenLeft;
  logic [4:0]       bitCnt;
  logic [2:0]       rdBit;
  logic [6:0]       byteSh;
  logic             phase;
  logic             sendAddr;
  logic             owner;
  logic             lastOwner;
  logic             winner;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign winner = req[1] & (~req[0] | ~lastOwner);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_POWER;
      cnt       <= '0;
      shiftReg  <= '0;
      addrLat   <= '0;
      lenLeft   <= '0;
      bitCnt    <= '0;
      rdBit     <= '0;
      byteSh    <= '0;
      phase     <= 1'b0;
      sendAddr  <= 1'b0;
      owner     <= 1'b0;
      lastOwner <= 1'b1;
      gnt       <= '0;
      done      <= '0;
      rdValid   <= 1'b0;
      rdData    <= '0;
      rdOwner   <= 1'b0;
      flashClk  <= 1'b0;
      flashMosi <= 1'b0;
      flashCs   <= 1'b1;
    end else begin
      gnt     <= '0;
      done    <= '0;
      rdValid <= 1'b0;
      case (state)
        WAIT_POWER: begin
          if (cnt == WAIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (req != 2'b00) begin
            owner     <= winner;
            lastOwner <= winner;
            gnt       <= winner ? 2'b10 : 2'b01;
            addrLat   <= winner ? addr1 : addr0;
            lenLeft   <= winner ? len1 : len0;
            // Zero-length requests skip the bus entirely and just report done.
            state     <= ((winner ? len1 : len0) == 6'd0) ? FINISH : LOAD_CMD;
          end
        end
        LOAD_CMD: begin
          flashCs  <= 1'b0;
          shiftReg <= {8'h03, 16'h0000};
          bitCnt   <= 5'd8;
          sendAddr <= 1'b0;
          phase    <= 1'b0;
          state    <= SEND;
        end
        LOAD_ADDR: begin
          flashClk <= 1'b0;
          shiftReg <= addrLat;
          bitCnt   <= 5'd24;
          sendAddr <= 1'b1;
          phase    <= 1'b0;
          state    <= SEND;
        end
        SEND: begin
          if (!phase) begin
            flashClk  <= 1'b0;
            flashMosi <= shiftReg[23];
            shiftReg  <= {shiftReg[22:0], 1'b0};
            bitCnt    <= bitCnt - 1'b1;
            phase     <= 1'b1;
          end else begin
            flashClk <= 1'b1;
            phase    <= 1'b0;
            if (bitCnt == 5'd0) begin
              rdBit <= '0;
              state <= sendAddr ? READ : LOAD_ADDR;
            end
          end
        end
        READ: begin
          if (!phase) begin
            flashClk  <= 1'b0;
            flashMosi <= 1'b0;
            phase     <= 1'b1;
          end else begin
            flashClk <= 1'b1;
            phase    <= 1'b0;
            byteSh   <= {byteSh[5:0], flashMiso};
            rdBit    <= rdBit + 1'b1;
            // The 8th bit goes straight into rdData, so byteSh only keeps 7.
            if (rdBit == 3'd7) begin
              rdData  <= {byteSh, flashMiso};
              rdValid <= 1'b1;
              rdOwner <= owner;
              lenLeft <= lenLeft - 1'b1;
              if (lenLeft == 6'd1) state <= FINISH;
            end
          end
        end
        FINISH: begin
          flashCs  <= 1'b1;
          flashClk <= 1'b0;
          done     <= owner ? 2'b10 : 2'b01;
          cnt      <= '0;
          state    <= DESELECT;
        end
        DESELECT: begin
          if (cnt == DESEL_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= WAIT_POWER;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Randomized bench for flash_read_arbiter: behavioural SPI flash, bus monitor
// and a transaction-level model of arbitration order and returned data.
module tb_flash_read_arbiter;
  localparam int CLK_FREQ  = 100000;
  localparam int WAIT_MS   = 1;
  localparam int MIN_DES   = 4;
  localparam int STARTUP   = WAIT_MS * CLK_FREQ / 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [23:0] addr0 = '0, addr1 = '0;
  logic [5:0]  len0 = '0, len1 = '0;
  logic        flashMiso = 1'b0;
  logic [1:0]  gnt, done;
  logic        busy, rdValid, rdOwner, flashClk, flashMosi, flashCs;
  logic [7:0]  rdData;

  flash_read_arbiter #(.CLK_FREQ(CLK_FREQ), .STARTUP_WAIT_MS(WAIT_MS), .MIN_DESELECT(MIN_DES)) dut (
    .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .gnt(gnt), .busy(busy), .rdData(rdData), .rdValid(rdValid), .rdOwner(rdOwner), .done(done),
    .flashClk(flashClk), .flashMosi(flashMosi), .flashMiso(flashMiso), .flashCs(flashCs)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edges; logic [7:0] cmd; logic [23:0] addr;
    int fallCyc; int riseCyc; int firstRise; int lastRise;
  } txn_t;

  int total = 0, bad = 0, cyc = 0, exclErr = 0, mosiReadErr = 0, modelLast = 1;
  txn_t       txnQ[$];
  logic [8:0] rdQ[$], expQ[$];
  int         rdCyc[$], doneCyc[$];
  logic [1:0] gntQ[$], doneQ[$];

  // Flash contents: the power-up pattern at 0..3, a scrambled address elsewhere.
  function automatic logic [7:0] memByte(input logic [23:0] a);
    case (a)
      24'd0:   memByte = 8'hDE;
      24'd1:   memByte = 8'hAD;
      24'd2:   memByte = 8'hBE;
      24'd3:   memByte = 8'hEF;
      default: memByte = a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  task automatic expectBytes(input int o, input logic [23:0] a, input int n);
    for (int i = 0; i < n; i++) expQ.push_back({1'(o), memByte(a + 24'(i))});
  endtask

  task automatic clearLogs;
    txnQ.delete(); rdQ.delete(); rdCyc.delete(); gntQ.delete(); doneQ.delete(); doneCyc.delete();
  endtask

  initial forever begin @(posedge clk); cyc++; end

  // SPI flash slave and bus monitor, sampled mid-cycle.
  initial begin
    logic pc, pcs; int bitCnt, idx; logic [31:0] hdr; logic [7:0] b; txn_t t;
    pc = 1'b0; pcs = 1'b1; bitCnt = 0; hdr = '0;
    t.edges = 0; t.cmd = '0; t.addr = '0; t.fallCyc = 0; t.riseCyc = 0; t.firstRise = 0; t.lastRise = 0;
    forever begin
      @(negedge clk);
      if (pcs && !flashCs) begin t.edges = 0; t.fallCyc = cyc; t.firstRise = -1; bitCnt = 0; hdr = '0; end
      if (!flashCs && flashClk && !pc) begin
        if (t.edges == 0) t.firstRise = cyc;
        t.edges++; t.lastRise = cyc;
        if (bitCnt < 32) hdr = {hdr[30:0], flashMosi};
        else if (flashMosi !== 1'b0) mosiReadErr++;
        bitCnt++;
      end
      if (!flashCs && !flashClk && pc && bitCnt >= 32) begin
        idx = bitCnt - 32;
        b = memByte(hdr[23:0] + 24'(idx / 8));
        flashMiso = b[7 - (idx % 8)];
      end
      if (!pcs && flashCs) begin
        t.cmd = hdr[31:24]; t.addr = hdr[23:0]; t.riseCyc = cyc;
        txnQ.push_back(t); flashMiso = 1'b0;
      end
      if (rdValid) begin rdQ.push_back({rdOwner, rdData}); rdCyc.push_back(cyc); end
      if (gnt != 2'b00) gntQ.push_back(gnt);
      if (done != 2'b00) begin doneQ.push_back(done); doneCyc.push_back(cyc); end
      if (gnt === 2'b11 || done === 2'b11) exclErr++;
      pc = flashClk; pcs = flashCs;
    end
  end

  task automatic test_reset;
    rst = 1'b1; req = 2'b00;
    repeat (3) @(negedge clk);
    total++; if ({flashCs, flashClk, flashMosi} !== 3'b100) begin bad++; $display("FAIL reset_pins cs/clk/mosi got=%b want=100", {flashCs, flashClk, flashMosi}); end
    total++; if ({gnt, done, rdValid} !== 5'b0) begin bad++; $display("FAIL reset_strobes gnt/done/rdValid got=%b want=00000", {gnt, done, rdValid}); end
    total++; if ({rdOwner, rdData} !== 9'h0) begin bad++; $display("FAIL reset_rd owner/data got=%h want=0", {rdOwner, rdData}); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busy); end
  endtask

  task automatic test_powerup;
    int n, mis, sp; bit csLow;
    clearLogs();
    addr0 = 24'h000000; len0 = 6'd4; req = 2'b01; rst = 1'b0;
    n = 0; csLow = 0;
    while (gnt !== 2'b01 && n < STARTUP + 20) begin
      @(negedge clk); n++;
      if (flashCs !== 1'b1) csLow = 1;
    end
    req = 2'b00; modelLast = 0;
    total++; if (n < STARTUP + 1 || n > STARTUP + 2 || csLow) begin bad++; $display("FAIL powerup_grant got cycles=%0d csLow=%0d want %0d..%0d with cs high", n, csLow, STARTUP + 1, STARTUP + 2); end
    for (int i = 0; i < 2000 && doneQ.size() < 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    total++; if (doneQ.size() != 1 || doneQ[0] !== 2'b01) begin bad++; $display("FAIL powerup_done got count=%0d want one done=01", doneQ.size()); end
    total++; if (txnQ.size() != 1 || txnQ[0].cmd !== 8'h03 || txnQ[0].addr !== 24'h0 || txnQ[0].edges != 64) begin
      bad++; $display("FAIL powerup_bus got txns=%0d cmd=%h addr=%h edges=%0d want 1/03/000000/64", txnQ.size(), txnQ[0].cmd, txnQ[0].addr, txnQ[0].edges); end
    total++; if (txnQ.size() != 1 || txnQ[0].firstRise - txnQ[0].fallCyc < 1 || txnQ[0].riseCyc - txnQ[0].lastRise < 1) begin
      bad++; $display("FAIL powerup_cs_margin got lead=%0d lag=%0d want >=1 each", txnQ[0].firstRise - txnQ[0].fallCyc, txnQ[0].riseCyc - txnQ[0].lastRise); end
    expQ.delete(); expectBytes(0, 24'h0, 4);
    mis = (rdQ.size() != expQ.size()) ? 1 : 0;
    if (mis == 0) foreach (rdQ[i]) if (rdQ[i] !== expQ[i]) mis++;
    total++; if (mis != 0) begin bad++; $display("FAIL powerup_data got %0d bytes first=%h want %0d bytes first=%h (%0d differ)", rdQ.size(), rdQ[0], expQ.size(), expQ[0], mis); end
    sp = 0;
    for (int i = 1; i < rdCyc.size(); i++) if (rdCyc[i] - rdCyc[i-1] != 16) sp++;
    total++; if (sp != 0 || rdCyc.size() != 4 || doneCyc.size() != 1 || doneCyc[0] - rdCyc[3] < 1 || doneCyc[0] - rdCyc[3] > 2) begin
      bad++; $display("FAIL powerup_timing got badSpacing=%0d rdCount=%0d doneLag=%0d want 0/4/1..2", sp, rdCyc.size(), doneCyc[0] - rdCyc[3]); end
  endtask

  task automatic test_max_len;
    int mis, sp;
    clearLogs();
    addr1 = 24'hFFFFF0; len1 = 6'd32; req = 2'b10;
    for (int i = 0; i < 3000 && doneQ.size() < 1; i++) begin @(negedge clk); if (gnt[1]) req[1] = 1'b0; end
    req = 2'b00; modelLast = 1;
    repeat (2) @(negedge clk);
    total++; if (txnQ.size() != 1 || txnQ[0].edges != 288 || txnQ[0].addr !== 24'hFFFFF0) begin
      bad++; $display("FAIL maxlen_edges got txns=%0d edges=%0d addr=%h want 1/288/fffff0", txnQ.size(), txnQ[0].edges, txnQ[0].addr); end
    expQ.delete(); expectBytes(1, 24'hFFFFF0, 32);
    mis = (rdQ.size() != expQ.size()) ? 1 : 0;
    if (mis == 0) foreach (rdQ[i]) if (rdQ[i] !== expQ[i]) mis++;
    total++; if (mis != 0) begin bad++; $display("FAIL maxlen_data got %0d bytes want %0d (%0d differ)", rdQ.size(), expQ.size(), mis); end
    total++; if (doneQ.size() != 1 || doneQ[0] !== 2'b10 || gntQ.size() != 1 || gntQ[0] !== 2'b10) begin
      bad++; $display("FAIL maxlen_handshake got gnts=%0d dones=%0d done0=%b want 1/1/10", gntQ.size(), doneQ.size(), doneQ[0]); end
    sp = 0;
    for (int i = 1; i < rdCyc.size(); i++) if (rdCyc[i] - rdCyc[i-1] != 16) sp++;
    total++; if (sp != 0) begin bad++; $display("FAIL maxlen_spacing got %0d gaps not 16 want 0", sp); end
  endtask

  task automatic test_tie_round_robin;
    int mis, o0, o1;
    for (int round = 0; round < 2; round++) begin
      clearLogs();
      addr0 = 24'h100000; addr1 = 24'h200000; len0 = 6'd2; len1 = 6'd2;
      o0 = (modelLast == 1) ? 0 : 1; o1 = 1 - o0; modelLast = o1;
      expQ.delete(); expectBytes(o0, o0 ? 24'h200000 : 24'h100000, 2); expectBytes(o1, o1 ? 24'h200000 : 24'h100000, 2);
      req = 2'b11;
      for (int i = 0; i < 3000 && doneQ.size() < 2; i++) begin
        @(negedge clk);
        if (gnt[0]) req[0] = 1'b0;
        if (gnt[1]) req[1] = 1'b0;
      end
      req = 2'b00;
      repeat (2) @(negedge clk);
      total++; if (gntQ.size() != 2 || gntQ[0] !== 2'(1 << o0) || gntQ[1] !== 2'(1 << o1)) begin
        bad++; $display("FAIL tie_order round=%0d got %0d gnts first=%b second=%b want %b then %b", round, gntQ.size(), gntQ[0], gntQ[1], 2'(1 << o0), 2'(1 << o1)); end
      total++; if (txnQ.size() != 2 || txnQ[0].addr !== 24'h100000 || txnQ[1].addr !== 24'h200000) begin
        bad++; $display("FAIL tie_addr round=%0d got txns=%0d %h,%h want 100000,200000", round, txnQ.size(), txnQ[0].addr, txnQ[1].addr); end
      total++; if (txnQ.size() != 2 || txnQ[1].fallCyc - txnQ[0].riseCyc < MIN_DES + 2) begin
        bad++; $display("FAIL tie_gap round=%0d got %0d cycles want >=%0d", round, txnQ[1].fallCyc - txnQ[0].riseCyc, MIN_DES + 2); end
      mis = (rdQ.size() != expQ.size()) ? 1 : 0;
      if (mis == 0) foreach (rdQ[i]) if (rdQ[i] !== expQ[i]) mis++;
      total++; if (mis != 0) begin bad++; $display("FAIL tie_data round=%0d got %0d bytes want %0d (%0d differ)", round, rdQ.size(), expQ.size(), mis); end
    end
  endtask

  task automatic test_len_zero;
    int n; bit csLow;
    clearLogs();
    len0 = 6'd0; addr0 = 24'h123456; req = 2'b01; n = 0;
    while (gnt !== 2'b01 && n < 100) begin @(negedge clk); n++; end
    req = 2'b00; modelLast = 0;
    @(negedge clk);
    total++; if (done !== 2'b01) begin bad++; $display("FAIL len0_done got=%b want=01 one cycle after gnt", done); end
    csLow = 0;
    repeat (12) begin @(negedge clk); if (flashCs !== 1'b1) csLow = 1; end
    total++; if (csLow || txnQ.size() != 0 || rdQ.size() != 0 || doneQ.size() != 1) begin
      bad++; $display("FAIL len0_quiet got csLow=%0d txns=%0d rd=%0d dones=%0d want 0/0/0/1", csLow, txnQ.size(), rdQ.size(), doneQ.size()); end
  endtask

  task automatic test_reset_mid_read;
    int seen, n, mis; logic [23:0] a;
    clearLogs();
    addr0 = 24'($urandom); len0 = 6'd8; req = 2'b01; seen = 0;
    for (int i = 0; i < 2000 && seen < 3; i++) begin
      @(negedge clk);
      if (gnt[0]) req[0] = 1'b0;
      if (rdValid) seen++;
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if (flashCs !== 1'b1 || flashClk !== 1'b0 || done !== 2'b00) begin
      bad++; $display("FAIL midreset_pins got cs=%b clk=%b done=%b want 1/0/00", flashCs, flashClk, done); end
    @(negedge clk);
    rst = 1'b0; modelLast = 1; n = 0;
    while (busy !== 1'b0 && n < STARTUP + 20) begin @(negedge clk); n++; end
    total++; if (n < STARTUP || n > STARTUP + 1 || doneQ.size() != 0) begin
      bad++; $display("FAIL midreset_wait got busyCycles=%0d dones=%0d want %0d..%0d/0", n, doneQ.size(), STARTUP, STARTUP + 1); end
    clearLogs();
    a = 24'($urandom); addr1 = a; len1 = 6'd3; req = 2'b10;
    for (int i = 0; i < 1000 && doneQ.size() < 1; i++) begin @(negedge clk); if (gnt[1]) req[1] = 1'b0; end
    req = 2'b00;
    repeat (2) @(negedge clk);
    expQ.delete(); expectBytes(1, a, 3);
    mis = (rdQ.size() != expQ.size()) ? 1 : 0;
    if (mis == 0) foreach (rdQ[i]) if (rdQ[i] !== expQ[i]) mis++;
    total++; if (mis != 0 || doneQ.size() != 1 || doneQ[0] !== 2'b10) begin
      bad++; $display("FAIL midreset_resume got %0d bytes (%0d differ) dones=%0d want 3 bytes, one done=10", rdQ.size(), mis, doneQ.size()); end
  endtask

  task automatic test_withdrawn;
    clearLogs();
    addr0 = 24'($urandom); len0 = 6'd4; req = 2'b01;
    for (int i = 0; i < 100 && req[0]; i++) begin @(negedge clk); if (gnt[0]) req[0] = 1'b0; end
    modelLast = 0;
    repeat (5) @(negedge clk);
    req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    for (int i = 0; i < 1000 && doneQ.size() < 1; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    total++; if (gntQ.size() != 1 || gntQ[0] !== 2'b01 || txnQ.size() != 1 || doneQ.size() != 1) begin
      bad++; $display("FAIL withdrawn got gnts=%0d txns=%0d dones=%0d want 1/1/1", gntQ.size(), txnQ.size(), doneQ.size()); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 16; it++) begin
      logic [1:0] pat; logic [23:0] a[2]; int l[2]; int ord[$]; int nTxn, mis, eBad, gBad;
      pat = 2'($urandom_range(1, 3));
      a[0] = 24'($urandom); a[1] = 24'($urandom);
      l[0] = $urandom_range(0, 32); l[1] = $urandom_range(0, 32);
      ord.delete();
      if (pat == 2'b11) begin ord.push_back(modelLast == 1 ? 0 : 1); ord.push_back(modelLast == 1 ? 1 : 0); end
      else ord.push_back(pat == 2'b10 ? 1 : 0);
      modelLast = ord[ord.size() - 1];
      expQ.delete(); nTxn = 0;
      foreach (ord[k]) begin expectBytes(ord[k], a[ord[k]], l[ord[k]]); if (l[ord[k]] != 0) nTxn++; end
      clearLogs();
      addr0 = a[0]; addr1 = a[1]; len0 = 6'(l[0]); len1 = 6'(l[1]); req = pat;
      for (int i = 0; i < 3000 && doneQ.size() < ord.size(); i++) begin
        @(negedge clk);
        if (gnt[0]) req[0] = 1'b0;
        if (gnt[1]) req[1] = 1'b0;
      end
      req = 2'b00;
      repeat (2) @(negedge clk);
      gBad = (gntQ.size() != ord.size() || doneQ.size() != ord.size()) ? 1 : 0;
      if (gBad == 0) foreach (ord[k]) if (gntQ[k] !== 2'(1 << ord[k]) || doneQ[k] !== 2'(1 << ord[k])) gBad++;
      total++; if (gBad != 0) begin bad++; $display("FAIL rand_order it=%0d pat=%b got gnts=%0d dones=%0d want %0d each in model order", it, pat, gntQ.size(), doneQ.size(), ord.size()); end
      mis = (rdQ.size() != expQ.size()) ? 1 : 0;
      if (mis == 0) foreach (rdQ[i]) if (rdQ[i] !== expQ[i]) mis++;
      total++; if (mis != 0) begin bad++; $display("FAIL rand_data it=%0d got %0d bytes want %0d (%0d differ)", it, rdQ.size(), expQ.size(), mis); end
      eBad = (txnQ.size() != nTxn) ? 1 : 0;
      if (eBad == 0) begin
        int j; j = 0;
        foreach (ord[k]) if (l[ord[k]] != 0) begin
          if (txnQ[j].edges != 32 + 8 * l[ord[k]] || txnQ[j].cmd !== 8'h03 || txnQ[j].addr !== a[ord[k]]) eBad++;
          j++;
        end
      end
      total++; if (eBad != 0) begin bad++; $display("FAIL rand_bus it=%0d got txns=%0d want %0d (%0d wrong edges/cmd/addr)", it, txnQ.size(), nTxn, eBad); end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_max_len();
    test_tie_round_robin();
    test_len_zero();
    test_reset_mid_read();
    test_withdrawn();
    test_random();
    total++; if (exclErr != 0) begin bad++; $display("FAIL exclusive got %0d cycles with both owners want 0", exclErr); end
    total++; if (mosiReadErr != 0) begin bad++; $display("FAIL mosi_read got %0d high bits during READ want 0", mosiReadErr); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got no finish want finish before 90000 cycles");
    $fatal(1);
  end

endmodule
